// File: rtl/dest_reg_sel_n_if.sv
// ============================================================================
// Module   : dest_reg_sel_n_if
// Brief    : Decode-side strobes and register-file select bus for dest_reg_sel_n.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dest_reg_sel_n_if #(
  parameter int N_REGS = 3
);
  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic              ldd;
  logic              ld_idx;
  logic [IW-1:0]     idx_in;
  logic [IW-1:0]     limit;
  logic [N_REGS-1:0] sel;
  logic [IW-1:0]     idx;
  logic              wrap;
  logic              err;

  modport master (
    output ldd, ld_idx, idx_in, limit,
    input  sel, idx, wrap, err
  );

  modport slave (
    input  ldd, ld_idx, idx_in, limit,
    output sel, idx, wrap, err
  );
endinterface

`default_nettype wire

// File: rtl/dest_reg_sel_n.sv
// ============================================================================
// Module   : dest_reg_sel_n
// Brief    : One-hot destination-register pointer with load, runtime wrap limit
//            and wrap pulse. Optional macro DEST_SEL_ONEHOT_CHECK_EN adds a
//            sticky one-hot corruption flag and recovery on the next strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dest_reg_sel_n #(
  parameter int N_REGS    = 3,
  parameter int RESET_IDX = N_REGS - 1
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  dest_reg_sel_n_if.slave   bus
);
  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IW-1:0]     c_max_idx   = IW'(N_REGS - 1);
  localparam logic [N_REGS-1:0] c_reset_sel = N_REGS'(1) << RESET_IDX;

  logic [N_REGS-1:0] sel_q, sel_d;
  logic              wrap_q, wrap_d;
  logic [IW-1:0]     idx_cur;
  logic [IW-1:0]     lim;
  logic [IW-1:0]     ld_val;

  // Lowest set bit wins, so a corrupted state still yields a defined index.
  always_comb begin
    idx_cur = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (sel_q[i]) idx_cur = IW'(i);
    end
  end

  assign lim    = (bus.limit > c_max_idx) ? c_max_idx : bus.limit;
  assign ld_val = (bus.idx_in > lim) ? lim : bus.idx_in;

`ifdef DEST_SEL_ONEHOT_CHECK_EN
  logic err_q, err_d;
  logic bad_state;

  assign bad_state = ($countones(sel_q) != 1);
  assign err_d     = err_q | bad_state;
`endif

  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (bus.ld_idx) begin
      sel_d = N_REGS'(1) << ld_val;
    end else if (bus.ldd) begin
`ifdef DEST_SEL_ONEHOT_CHECK_EN
      if (bad_state) begin
        sel_d = c_reset_sel;
      end else
`endif
      if (idx_cur >= lim) begin
        sel_d  = N_REGS'(1);
        wrap_d = 1'b1;
      end else begin
        sel_d = N_REGS'(1) << (idx_cur + IW'(1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_q  <= c_reset_sel;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef DEST_SEL_ONEHOT_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.sel  = sel_q;
  assign bus.idx  = idx_cur;
  assign bus.wrap = wrap_q;
endmodule

`default_nettype wire

// File: tb/tb_dest_reg_sel_n.sv
// ============================================================================
// Module   : tb_dest_reg_sel_n
// Brief    : Self-checking bench for dest_reg_sel_n at N_REGS=3 and N_REGS=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dest_reg_sel_n;
  logic clk = 1'b0;
  logic rst3_n, rst8_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dest_reg_sel_n_if #(.N_REGS(3)) bus3 ();
  dest_reg_sel_n_if #(.N_REGS(8)) bus8 ();

  dest_reg_sel_n #(.N_REGS(3)) u_dut3 (.clk_i(clk), .rst_ni(rst3_n), .bus(bus3));
  dest_reg_sel_n #(.N_REGS(8)) u_dut8 (.clk_i(clk), .rst_ni(rst8_n), .bus(bus8));

  typedef struct {
    bit rst_n;
    bit ldd;
    bit ld;
    int idx_in;
    int limit;
    int exp_idx;
    bit exp_wrap;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pointer: plain index arithmetic from the selector's rules.
  function automatic void model_step(input int n, input int ridx, input bit rst_n,
                                     input bit ldd, input bit ld, input int idx_in,
                                     input int limit, inout int idx, inout bit wrap);
    int l;
    l = (limit < n - 1) ? limit : n - 1;
    if (!rst_n) begin
      idx = ridx; wrap = 0;
    end else if (ld) begin
      idx = (idx_in < l) ? idx_in : l; wrap = 0;
    end else if (ldd) begin
      if (idx >= l) begin idx = 0; wrap = 1; end
      else begin idx = idx + 1; wrap = 0; end
    end else begin
      wrap = 0;
    end
  endfunction

  task automatic drive3(input bit rst_n, input bit ldd, input bit ld, input int idx_in, input int limit);
    rst3_n = rst_n; bus3.ldd = ldd; bus3.ld_idx = ld;
    bus3.idx_in = 2'(idx_in); bus3.limit = 2'(limit);
  endtask

  task automatic drive8(input bit rst_n, input bit ldd, input bit ld, input int idx_in, input int limit);
    rst8_n = rst_n; bus8.ldd = ldd; bus8.ld_idx = ld;
    bus8.idx_in = 3'(idx_in); bus8.limit = 3'(limit);
  endtask

  vec_t vecs[$];
  int   m3_idx, m8_idx;
  bit   m3_wrap, m8_wrap;

  initial begin
    drive3(0, 0, 0, 0, 2);
    drive8(0, 0, 0, 0, 7);

    // N=3 legacy order: 2 -> 0 -> 1 -> 2 -> 0
    tick();
    check("n3_reset_idx", int'(bus3.idx), 2);
    check("n3_reset_sel", int'(bus3.sel), 4);
    check("n3_reset_wrap", int'(bus3.wrap), 0);
    check("n3_reset_err", int'(bus3.err), 0);
    begin
      int exp_i[4] = '{0, 1, 2, 0};
      int exp_w[4] = '{1, 0, 0, 1};
      drive3(1, 1, 0, 0, 2);
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("n3_seq_idx%0d", k), int'(bus3.idx), exp_i[k]);
        check($sformatf("n3_seq_sel%0d", k), int'(bus3.sel), 1 << exp_i[k]);
        check($sformatf("n3_seq_wrap%0d", k), int'(bus3.wrap), exp_w[k]);
      end
      drive3(1, 0, 0, 0, 2);
      tick();
      check("n3_hold_wrap", int'(bus3.wrap), 0);
      check("n3_hold_idx", int'(bus3.idx), 0);
    end

    // N=8 table: reset, limit-5 walk, load priority, clamps, lowered limit, reset override
    vecs = '{
      '{0, 0, 0, 0, 5, 7, 0},
      '{1, 1, 0, 0, 5, 0, 1},
      '{1, 1, 0, 0, 5, 1, 0},
      '{1, 1, 0, 0, 5, 2, 0},
      '{1, 1, 0, 0, 5, 3, 0},
      '{1, 1, 0, 0, 5, 4, 0},
      '{1, 1, 0, 0, 5, 5, 0},
      '{1, 1, 0, 0, 5, 0, 1},
      '{1, 1, 1, 3, 7, 3, 0},
      '{1, 0, 1, 6, 4, 4, 0},
      '{1, 1, 0, 0, 2, 0, 1},
      '{1, 1, 0, 0, 7, 1, 0},
      '{0, 1, 0, 0, 7, 7, 0},
      '{1, 1, 0, 0, 7, 0, 1},
      '{1, 0, 0, 0, 7, 0, 0},
      '{1, 0, 1, 7, 7, 7, 0},
      '{1, 0, 0, 0, 7, 7, 0}
    };
    foreach (vecs[k]) begin
      drive8(vecs[k].rst_n, vecs[k].ldd, vecs[k].ld, vecs[k].idx_in, vecs[k].limit);
      tick();
      check($sformatf("n8_vec%0d_idx", k), int'(bus8.idx), vecs[k].exp_idx);
      check($sformatf("n8_vec%0d_sel", k), int'(bus8.sel), 1 << vecs[k].exp_idx);
      check($sformatf("n8_vec%0d_wrap", k), int'(bus8.wrap), int'(vecs[k].exp_wrap));
    end

    // Randomized run on both instances against the reference model
    m3_idx = 0; m3_wrap = 0; m8_idx = 0; m8_wrap = 0;
    for (int c = 0; c < 400; c++) begin
      bit r3, r8, l3, l8, s3, s8;
      int i3, i8, lm3, lm8;
      r3 = (c == 0) || ($urandom_range(0, 19) != 0) ? (c != 0) : 1'b0;
      r8 = (c == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
      s3 = $urandom_range(0, 3) != 0;  l3 = $urandom_range(0, 5) == 0;
      s8 = $urandom_range(0, 3) != 0;  l8 = $urandom_range(0, 5) == 0;
      i3 = $urandom_range(0, 3);  lm3 = $urandom_range(0, 3);
      i8 = $urandom_range(0, 7);  lm8 = $urandom_range(0, 7);
      drive3(r3, s3, l3, i3, lm3);
      drive8(r8, s8, l8, i8, lm8);
      model_step(3, 2, r3, s3, l3, i3, lm3, m3_idx, m3_wrap);
      model_step(8, 7, r8, s8, l8, i8, lm8, m8_idx, m8_wrap);
      tick();
      check("rnd3_idx", int'(bus3.idx), m3_idx);
      check("rnd3_sel", int'(bus3.sel), 1 << m3_idx);
      check("rnd3_wrap", int'(bus3.wrap), int'(m3_wrap));
      check("rnd3_err", int'(bus3.err), 0);
      check("rnd8_idx", int'(bus8.idx), m8_idx);
      check("rnd8_sel", int'(bus8.sel), 1 << m8_idx);
      check("rnd8_wrap", int'(bus8.wrap), int'(m8_wrap));
      check("rnd8_err", int'(bus8.err), 0);
    end

`ifdef DEST_SEL_ONEHOT_CHECK_EN
    // Corrupted state: ERR sets next edge and sticks, LDD recovers to reset index
    drive3(1, 0, 0, 0, 2);
    tick();
    force u_dut3.sel_q = 3'b011;
    tick();
    check("err_set", int'(bus3.err), 1);
    release u_dut3.sel_q;
    check("err_hold_sel", int'(bus3.sel), 3);
    drive3(1, 1, 0, 0, 2);
    tick();
    check("err_recover_sel", int'(bus3.sel), 4);
    check("err_sticky", int'(bus3.err), 1);
    drive3(0, 0, 0, 0, 2);
    tick();
    check("err_cleared", int'(bus3.err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
